// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
//
// Self-test engine for a 4-input, 1-output combinational block. It walks the
// input vectors {M,N,P,Q} = 0..15 and holds each one for a dwell time chosen
// by the two low index bits. At the end of each dwell it samples the block's
// Z output and compares it against EXP_TABLE. After vector 15 it reports the
// mismatch count, the first failing vector and a pass flag.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          single-cycle run request (ignored while busy)
//   z_in           Z output of the block under test
//   m/n/p/q_out    registered vector drive, M is the MSB of the index
//   busy           vectors are being applied
//   done           run complete, held until the next start
//   pass           done with zero mismatches
//   err_count      mismatches in the current/last run (0..16)
//   first_err_idx  index of the first mismatch, valid with err_valid
//   err_valid      at least one mismatch seen in the current/last run
// ---------------------------------------------------------------------------
module truth_table_checker #(
    parameter logic [15:0] EXP_TABLE = 16'h6996,
    parameter int          DWELL0    = 7,
    parameter int          DWELL1    = 2,
    parameter int          DWELL2    = 9,
    parameter int          DWELL3    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       z_in,
    output logic       m_out,
    output logic       n_out,
    output logic       p_out,
    output logic       q_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_err_idx,
    output logic       err_valid
);

    // A dwell of 0 would never reach the sampling point, so it is clamped to 1.
    localparam int D0 = (DWELL0 < 1) ? 1 : DWELL0;
    localparam int D1 = (DWELL1 < 1) ? 1 : DWELL1;
    localparam int D2 = (DWELL2 < 1) ? 1 : DWELL2;
    localparam int D3 = (DWELL3 < 1) ? 1 : DWELL3;

    localparam int DMAX01 = (D0 > D1) ? D0 : D1;
    localparam int DMAX23 = (D2 > D3) ? D2 : D3;
    localparam int DMAX   = (DMAX01 > DMAX23) ? DMAX01 : DMAX23;
    localparam int CNT_W  = (DMAX < 2) ? 1 : $clog2(DMAX + 1);

    localparam logic [4:0] ERR_MAX = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] dwell_of(input logic [1:0] sel);
        logic [CNT_W-1:0] d;
        case (sel)
            2'd0:    d = CNT_W'(D0);
            2'd1:    d = CNT_W'(D1);
            2'd2:    d = CNT_W'(D2);
            default: d = CNT_W'(D3);
        endcase
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       vec_q, vec_d;
    logic [4:0]       err_count_q, err_count_d;
    logic [3:0]       first_err_idx_q, first_err_idx_d;
    logic             err_valid_q, err_valid_d;

    logic             launch;
    logic             sample;
    logic             last_vec;
    logic             mismatch;
    logic [3:0]       idx_inc;

    // start is honoured from IDLE and DONE only; a pulse mid-run is dropped.
    assign launch   = start && (state_q != APPLY);
    // The counter holds the remaining hold cycles; the edge that ends the
    // final hold cycle is the only point where z_in is looked at.
    assign sample   = (state_q == APPLY) && (cnt_q == CNT_W'(1));
    assign last_vec = (idx_q == 4'd15);
    assign mismatch = sample && (z_in != EXP_TABLE[idx_q]);
    assign idx_inc  = idx_q + 4'd1;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY:   if (sample && last_vec) state_d = DONE;
            DONE:    if (start) state_d = APPLY;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            APPLY:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign pass = done && (err_count_q == 5'd0);

    // ---------------- datapath next values ----------------
    always_comb begin
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        vec_d           = vec_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        err_valid_d     = err_valid_q;

        if (launch) begin
            idx_d           = 4'd0;
            cnt_d           = dwell_of(2'd0);
            vec_d           = 4'd0;
            err_count_d     = 5'd0;
            first_err_idx_d = 4'd0;
            err_valid_d     = 1'b0;
        end else if (state_q == APPLY) begin
            if (sample) begin
                if (mismatch) begin
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + 5'd1;
                    end
                    if (!err_valid_q) begin
                        first_err_idx_d = idx_q;
                        err_valid_d     = 1'b1;
                    end
                end
                if (last_vec) begin
                    vec_d = 4'd0;
                end else begin
                    idx_d = idx_inc;
                    cnt_d = dwell_of(idx_inc[1:0]);
                    vec_d = idx_inc;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q           <= 4'd0;
            cnt_q           <= '0;
            vec_q           <= 4'd0;
            err_count_q     <= 5'd0;
            first_err_idx_q <= 4'd0;
            err_valid_q     <= 1'b0;
        end else begin
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            vec_q           <= vec_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            err_valid_q     <= err_valid_d;
        end
    end

    assign m_out         = vec_q[3];
    assign n_out         = vec_q[2];
    assign p_out         = vec_q[1];
    assign q_out         = vec_q[0];
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign err_valid     = err_valid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       z_in;
    logic       m_out, n_out, p_out, q_out;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_err_idx;
    logic       err_valid;

    truth_table_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .z_in          (z_in),
        .m_out         (m_out),
        .n_out         (n_out),
        .p_out         (p_out),
        .q_out         (q_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .err_valid     (err_valid)
    );

    always #5 clk = ~clk;

    // mode: 0 golden, 1 golden inverted at vectors 5/12, 2 stuck 0,
    //       3 stuck 1, 4 golden inverted except on the last hold cycle
    typedef struct {
        int         mode;
        bit         restart;   // extra start pulse during vector 3
        logic [4:0] cnt;
        logic [3:0] first;
        logic       ev;
        logic       ps;
    } rec_t;

    rec_t        tests[6];
    rec_t        sb_q[$];
    int          ends[16];
    logic [15:0] exp_tbl;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dw(input int i);
        case (i % 4)
            0: return 7;
            1: return 2;
            2: return 9;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_vec(input int c);
        for (int i = 0; i < 16; i++) if (c <= ends[i]) return i;
        return 0;
    endfunction

    function automatic logic [16:0] all_outs();
        return {m_out, n_out, p_out, q_out, busy, done, pass,
                err_count, first_err_idx, err_valid};
    endfunction

    // Drive z_in for the coming cycle from the vector the DUT presents.
    task automatic drive_z(input int mode, input int c);
        logic [3:0] v;
        logic       g;
        v = {m_out, n_out, p_out, q_out};
        g = exp_tbl[v];
        case (mode)
            1:       z_in = (v == 4'd5 || v == 4'd12) ? ~g : g;
            2:       z_in = 1'b0;
            3:       z_in = 1'b1;
            4:       z_in = (c == ends[v]) ? g : ~g;
            default: z_in = g;
        endcase
    endtask

    task automatic run(input rec_t r);
        rec_t got;
        int   extra;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.push_back(r);
        chk("clear_on_start_cnt", err_count, 0);
        chk("clear_on_start_ev", err_valid, 0);
        chk("clear_on_start_done", done, 0);
        chk("clear_on_start_pass", pass, 0);
        for (int c = 1; c <= 88; c++) begin
            chk("vector", {m_out, n_out, p_out, q_out}, exp_vec(c));
            chk("busy_in_run", busy, 1);
            drive_z(r.mode, c);
            if (r.restart && c == 20) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (c < 88 && done) chk("done_early", c, 88);
        end
        extra = 0;
        while (!done && extra < 20) begin
            @(posedge clk); #1;
            extra++;
        end
        chk("done_cycle", 88 + extra, 88);
        chk("busy_after", busy, 0);
        chk("vector_after", {m_out, n_out, p_out, q_out}, 0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            got = sb_q.pop_front();
            chk("err_count", err_count, got.cnt);
            chk("first_err_idx", first_err_idx, got.first);
            chk("err_valid", err_valid, got.ev);
            chk("pass", pass, got.ps);
        end
        // results hold in DONE
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", done, 1);
        chk("hold_cnt", err_count, r.cnt);
    endtask

    initial begin
        int acc;
        exp_tbl = 16'h6996;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            acc += dw(i);
            ends[i] = acc;
        end
        //          mode restart cnt first ev ps
        tests[0] = '{0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1};
        tests[1] = '{1, 1'b0, 5'd2, 4'd5, 1'b1, 1'b0};
        tests[2] = '{2, 1'b0, 5'd8, 4'd1, 1'b1, 1'b0};
        tests[3] = '{3, 1'b0, 5'd8, 4'd0, 1'b1, 1'b0};
        tests[4] = '{4, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1};
        tests[5] = '{0, 1'b1, 5'd0, 4'd0, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        z_in  = 1'b0;
        #12;
        chk("reset_outputs", all_outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_outputs", all_outs(), 0);

        for (int t = 0; t < 6; t++) run(tests[t]);

        // Reset during vector 6: everything drops at once, no resume.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 35; c++) begin
            drive_z(0, c);
            @(posedge clk); #1;
        end
        chk("vec6_before_reset", {m_out, n_out, p_out, q_out}, 6);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_reset", all_outs(), 0);

        run(tests[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
